// File: rtl/datapath_pkg.sv
// Shared types for the branch-predictor update scheduler: queued update record,
// 2-bit counter type, counter encodings and scheduler FSM states.
package datapath_pkg;

    // Widest table index the queued record can carry; instances use the low IDX_W bits.
    localparam int IDX_W_MAX = 16;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'd0;
    localparam ctr_t WNT = 2'd1;
    localparam ctr_t WT  = 2'd2;
    localparam ctr_t ST  = 2'd3;

    typedef struct packed {
        logic [IDX_W_MAX-1:0] idx;
        logic                 taken;
    } bp_upd_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPD_RD = 2'd1,
        S_UPD_WR = 2'd2
    } upd_state_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO of pending PHT updates; DEPTH must be a power of two so the
// pointers wrap naturally.
module bp_upd_fifo
    import datapath_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    CLK,
    input  logic    nRST,
    input  logic    push_i,
    input  bp_upd_t push_data_i,
    input  logic    pop_i,
    output bp_upd_t head_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int AW = $clog2(DEPTH);

    bp_upd_t          mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count_q says they are valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/bp_update_sched.sv
// Arbitrates the single-ported gshare PHT between fetch lookups and queued
// resolution updates (read-modify-write), and owns the global history register.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | serve fetch lookup, or issue read of queued update's counter
//   S_UPD_RD | counter read data valid; compute and register saturated value
//   S_UPD_WR | write updated counter back, pop the update
module bp_update_sched
    import datapath_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int IDX_W      = 8,
    parameter int STARVE_MAX = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             fetch_req,
    input  logic [31:0]      fetch_pc,
    output logic             fetch_gnt,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic             res_taken,
    output logic             res_ready,
    output logic             tbl_en,
    output logic             tbl_wen,
    output logic [IDX_W-1:0] tbl_addr,
    output ctr_t             tbl_wdata,
    input  ctr_t             tbl_rdata,
    output logic [IDX_W-1:0] ghr,
    output logic             busy
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    upd_state_t       state_q;
    ctr_t             ctr_q;
    logic [SW-1:0]    starve_q;
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_d;

    bp_upd_t          upd_in;
    bp_upd_t          head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             issue_rd;
    logic             forced;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] enq_idx;
    logic [IDX_W-1:0] head_idx;
    ctr_t             upd_ctr;

    assign fetch_idx = fetch_pc[IDX_W+1:2] ^ ghr_q;
    assign enq_idx   = res_pc[IDX_W+1:2] ^ ghr_q;
    assign head_idx  = head.idx[IDX_W-1:0];
    assign forced    = (starve_q == SW'(STARVE_MAX));

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign res_ready = !fifo_full;
    assign push      = res_valid && res_ready;
    assign ghr       = ghr_q;
    assign busy      = !fifo_empty || (state_q != S_IDLE);

    always_comb begin
        upd_in       = '0;
        upd_in.idx   = IDX_W_MAX'(enq_idx);
        upd_in.taken = res_taken;
    end

    bp_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .nRST        (nRST),
        .push_i      (push),
        .push_data_i (upd_in),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        if (head.taken) upd_ctr = (tbl_rdata == ST)  ? ST  : ctr_t'(tbl_rdata + 2'd1);
        else            upd_ctr = (tbl_rdata == SNT) ? SNT : ctr_t'(tbl_rdata - 2'd1);
    end

    always_comb begin
        fetch_gnt = 1'b0;
        tbl_en    = 1'b0;
        tbl_wen   = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = SNT;
        issue_rd  = 1'b0;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fetch_req && !forced) begin
                    fetch_gnt = 1'b1;
                    tbl_en    = 1'b1;
                    tbl_addr  = fetch_idx;
                end else if (!fifo_empty) begin
                    issue_rd  = 1'b1;
                    tbl_en    = 1'b1;
                    tbl_addr  = head_idx;
                end
            end
            S_UPD_WR: begin
                tbl_en    = 1'b1;
                tbl_wen   = 1'b1;
                tbl_addr  = head_idx;
                tbl_wdata = ctr_q;
                pop       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            ctr_q    <= SNT;
            starve_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fifo_empty || issue_rd)      starve_q <= '0;
                    else if (fetch_gnt && !forced)   starve_q <= starve_q + SW'(1);
                    if (issue_rd) state_q <= S_UPD_RD;
                end
                S_UPD_RD: begin
                    ctr_q    <= upd_ctr;
                    starve_q <= '0;
                    state_q  <= S_UPD_WR;
                end
                S_UPD_WR: begin
                    starve_q <= '0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The history shift uses the pre-shift value for the index just enqueued.
    always_comb begin
        ghr_d = ghr_q;
        if (push) ghr_d = {ghr_q[IDX_W-2:0], res_taken};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) ghr_q <= '0;
        else       ghr_q <= ghr_d;
    end

endmodule
